// File: rtl/pru_pkg.sv
// ----------------------------------------------------------------------------
// pru_pkg: shared field widths, command entry and queue FSM states for the PRU.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pru_pkg;

  localparam int COLOR_W = 2;
  localparam int ROW_W   = 9;
  localparam int COL_W   = 10;
  localparam int WIDTH_W = 10;
  localparam int HR_W    = 9;
  localparam int SHAPE_W = 2;
  localparam int CMD_W   = COLOR_W + ROW_W + COL_W + WIDTH_W + HR_W + SHAPE_W + 1;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [WIDTH_W-1:0] width;
    logic [HR_W-1:0]    height_radius;
    logic [SHAPE_W-1:0] shape_select;
    logic               subtract;
  } pru_cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } cmdq_state_e;

endpackage

`default_nettype wire

// File: rtl/pru_cmd_fifo.sv
// ----------------------------------------------------------------------------
// pru_cmd_fifo: circular entry buffer with separate occupancy count.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pru_cmd_fifo #(
  parameter int  DEPTH   = 8,
  parameter type ENTRY_T = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  ENTRY_T                   wdata,
  output ENTRY_T                   rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  ENTRY_T           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_nxt;
  logic             pop_ok;

  // A pop frees the head slot in the same cycle, so a full queue still
  // accepts a push when it is being drained.
  assign pop_ok  = pop && !clr && (count != '0);
  assign push_ok = push && !clr && ((count != FULL_CNT) || pop_ok);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/pru_cmd_queue.sv
// ----------------------------------------------------------------------------
// pru_cmd_queue: buffers decoded draw commands and replays them to the PRU one
// at a time. Optional statistics counters under PRU_CMDQ_STATS_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pru_cmd_queue
  import pru_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_start,
  input  logic [COLOR_W-1:0]     in_color,
  input  logic [ROW_W-1:0]       in_row,
  input  logic [COL_W-1:0]       in_col,
  input  logic [WIDTH_W-1:0]     in_width,
  input  logic [HR_W-1:0]        in_height_radius,
  input  logic [SHAPE_W-1:0]     in_shape_select,
  input  logic                   in_subtract,
  output logic                   in_full,
  input  logic                   pru_busy,
  input  logic                   pru_done,
  output logic                   out_start,
  output logic [COLOR_W-1:0]     out_color,
  output logic [ROW_W-1:0]       out_row,
  output logic [COL_W-1:0]       out_col,
  output logic [WIDTH_W-1:0]     out_width,
  output logic [HR_W-1:0]        out_height_radius,
  output logic [SHAPE_W-1:0]     out_shape_select,
  output logic                   out_subtract,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
`ifdef PRU_CMDQ_STATS_EN
  ,
  output logic [31:0]            issued_cnt,
  output logic [15:0]            dropped_cnt
`endif
);

  pru_cmd_t    in_cmd;
  pru_cmd_t    head;
  pru_cmd_t    out_cmd;
  cmdq_state_e state;
  cmdq_state_e state_nxt;
  logic        issue;
  logic        fifo_empty;
  logic        push_ok;
  logic        drop;

  assign in_cmd = {in_color, in_row, in_col, in_width, in_height_radius,
                   in_shape_select, in_subtract};
  assign drop   = in_start && !flush && !push_ok;

  pru_cmd_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (pru_cmd_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .push    (in_start),
    .pop     (issue),
    .wdata   (in_cmd),
    .rdata   (head),
    .count   (count),
    .full    (in_full),
    .empty   (fifo_empty),
    .push_ok (push_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // IDLE looks at the push being accepted this cycle as well as stored
  // entries, so a command into an empty queue reaches ISSUE one cycle later.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (!pru_busy && !flush && (!fifo_empty || push_ok)) state_nxt = ISSUE;
      end
      ISSUE: begin
        issue     = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (pru_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_start <= 1'b0;
      out_cmd   <= '0;
      overflow  <= 1'b0;
    end else begin
      out_start <= issue;
      if (issue) out_cmd <= head;
      if (flush)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  assign out_color         = out_cmd.color;
  assign out_row           = out_cmd.row;
  assign out_col           = out_cmd.col;
  assign out_width         = out_cmd.width;
  assign out_height_radius = out_cmd.height_radius;
  assign out_shape_select  = out_cmd.shape_select;
  assign out_subtract      = out_cmd.subtract;

`ifdef PRU_CMDQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      if (issue) issued_cnt <= issued_cnt + 32'd1;
      if (drop && (dropped_cnt != 16'hFFFF)) dropped_cnt <= dropped_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pru_cmd_queue.sv
// ----------------------------------------------------------------------------
// tb_pru_cmd_queue: directed self-checking bench with an expected-command queue.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pru_cmd_queue;
  import pru_pkg::*;

  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic                 in_start = 1'b0;
  logic [COLOR_W-1:0]   in_color = '0;
  logic [ROW_W-1:0]     in_row = '0;
  logic [COL_W-1:0]     in_col = '0;
  logic [WIDTH_W-1:0]   in_width = '0;
  logic [HR_W-1:0]      in_height_radius = '0;
  logic [SHAPE_W-1:0]   in_shape_select = '0;
  logic                 in_subtract = 1'b0;
  logic                 in_full;
  logic                 pru_busy = 1'b0;
  logic                 pru_done = 1'b0;
  logic                 out_start;
  logic [COLOR_W-1:0]   out_color;
  logic [ROW_W-1:0]     out_row;
  logic [COL_W-1:0]     out_col;
  logic [WIDTH_W-1:0]   out_width;
  logic [HR_W-1:0]      out_height_radius;
  logic [SHAPE_W-1:0]   out_shape_select;
  logic                 out_subtract;
  logic                 overflow;
  logic [$clog2(DEPTH):0] count;
`ifdef PRU_CMDQ_STATS_EN
  logic [31:0]          issued_cnt;
  logic [15:0]          dropped_cnt;
`endif

  int       vectors = 0;
  int       miscompares = 0;
  int       cyc = 0;
  int       n_starts = 0;
  int       last_start_cyc = -100;
  logic     prev_start = 1'b0;
  pru_cmd_t sb[$];

  pru_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .in_start          (in_start),
    .in_color          (in_color),
    .in_row            (in_row),
    .in_col            (in_col),
    .in_width          (in_width),
    .in_height_radius  (in_height_radius),
    .in_shape_select   (in_shape_select),
    .in_subtract       (in_subtract),
    .in_full           (in_full),
    .pru_busy          (pru_busy),
    .pru_done          (pru_done),
    .out_start         (out_start),
    .out_color         (out_color),
    .out_row           (out_row),
    .out_col           (out_col),
    .out_width         (out_width),
    .out_height_radius (out_height_radius),
    .out_shape_select  (out_shape_select),
    .out_subtract      (out_subtract),
    .overflow          (overflow),
    .count             (count)
`ifdef PRU_CMDQ_STATS_EN
    ,
    .issued_cnt        (issued_cnt),
    .dropped_cnt       (dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic pru_cmd_t mk(input int i);
    pru_cmd_t c;
    c.color         = COLOR_W'(i);
    c.row           = ROW_W'(37 * i + 5);
    c.col           = COL_W'(101 * i + 3);
    c.width         = WIDTH_W'(13 * i + 1);
    c.height_radius = HR_W'(7 * i + 2);
    c.shape_select  = SHAPE_W'(i >> 1);
    c.subtract      = i[0];
    return c;
  endfunction

  task automatic drive_push(input pru_cmd_t c, input bit accepted);
    {in_color, in_row, in_col, in_width, in_height_radius, in_shape_select, in_subtract} = c;
    in_start = 1'b1;
    if (accepted) sb.push_back(c);
    step();
    in_start = 1'b0;
  endtask

  task automatic pulse_done();
    pru_done = 1'b1;
    step();
    pru_done = 1'b0;
  endtask

  task automatic wait_starts(input int target, input string tag);
    for (int i = 0; i < 64; i++) begin
      if (n_starts >= target) break;
      step();
    end
    chk(tag, 64'(n_starts >= target), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"},     64'(count), 64'd0);
    chk({tag, "_in_full"},   64'(in_full), 64'd0);
    chk({tag, "_out_start"}, 64'(out_start), 64'd0);
    chk({tag, "_overflow"},  64'(overflow), 64'd0);
    chk({tag, "_out_fields"},
        64'({out_color, out_row, out_col, out_width, out_height_radius,
             out_shape_select, out_subtract}), 64'd0);
  endtask

  // Scoreboard: every start must present the oldest accepted command.
  always @(negedge clk) begin
    pru_cmd_t exp;
    if (rst_n && out_start) begin
      chk("start_single_cycle", 64'(prev_start), 64'd0);
      n_starts++;
      last_start_cyc = cyc;
      chk("start_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("start_fields",
            64'({out_color, out_row, out_col, out_width, out_height_radius,
                 out_shape_select, out_subtract}), 64'(exp));
      end
    end
    prev_start = out_start;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int       t0;
    int       d;
    int       base;
    pru_cmd_t a;

    // Reset state
    repeat (2) step();
    chk_reset_outputs("reset");
`ifdef PRU_CMDQ_STATS_EN
    chk("reset_issued_cnt",  64'(issued_cnt), 64'd0);
    chk("reset_dropped_cnt", 64'(dropped_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    step();

    // Single push into an empty queue: start two cycles later
    a.color = 2'd2; a.row = 9'd100; a.col = 10'd200; a.width = 10'd50;
    a.height_radius = 9'd30; a.shape_select = 2'd1; a.subtract = 1'b0;
    t0 = cyc;
    drive_push(a, 1'b1);
    chk("t1_count_after_push", 64'(count), 64'd1);
    chk("t1_no_early_start", 64'(out_start), 64'd0);
    step();
    chk("t1_start", 64'(out_start), 64'd1);
    chk("t1_latency", 64'(last_start_cyc - t0), 64'd2);
    chk("t1_count_drained", 64'(count), 64'd0);
    repeat (3) step();
    pulse_done();
    repeat (2) step();

    // Three back-to-back pushes, done 10 cycles after each start
    base = n_starts;
    for (int k = 0; k < 3; k++) drive_push(mk(k + 1), 1'b1);
    wait_starts(base + 1, "t2_start1");
    for (int k = 1; k < 3; k++) begin
      repeat (10) step();
      d = cyc;
      pulse_done();
      wait_starts(base + 1 + k, "t2_start_next");
      chk("t2_done_to_start", 64'(last_start_cyc - d), 64'd3);
    end
    repeat (10) step();
    pulse_done();
    step();
    chk("t2_count_empty", 64'(count), 64'd0);
`ifdef PRU_CMDQ_STATS_EN
    chk("t2_issued_cnt", 64'(issued_cnt), 64'd4);
`endif

    // Fill while PRU is stalled
    pru_busy = 1'b1;
    for (int k = 0; k < DEPTH; k++) drive_push(mk(10 + k), 1'b1);
    chk("t3_count_full", 64'(count), 64'(DEPTH));
    chk("t3_in_full", 64'(in_full), 64'd1);
    chk("t3_no_overflow", 64'(overflow), 64'd0);

    // Push coincident with the pop out of a full queue
    pru_busy = 1'b0;
    step();
    drive_push(mk(20), 1'b1);
    chk("t4_count_kept", 64'(count), 64'(DEPTH));
    chk("t4_in_full", 64'(in_full), 64'd1);
    chk("t4_no_overflow", 64'(overflow), 64'd0);
    chk("t4_start", 64'(out_start), 64'd1);

    // Push into a full queue with nothing popping is dropped
    pru_busy = 1'b1;
    drive_push(mk(21), 1'b0);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_count_after_drop", 64'(count), 64'(DEPTH));
`ifdef PRU_CMDQ_STATS_EN
    chk("t3_dropped_cnt", 64'(dropped_cnt), 64'd1);
`endif

    // Flush with entries queued and one command in flight
    flush = 1'b1;
    pru_busy = 1'b0;
    step();
    flush = 1'b0;
    sb.delete();
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_overflow", 64'(overflow), 64'd0);
    chk("t5_in_full", 64'(in_full), 64'd0);
    base = n_starts;
    repeat (3) step();
    pulse_done();
    repeat (12) step();
    chk("t5_no_start_after_flush", 64'(n_starts), 64'(base));

    // Reset during WAIT_DONE with four entries queued
    base = n_starts;
    for (int k = 0; k < 5; k++) drive_push(mk(30 + k), 1'b1);
    wait_starts(base + 1, "t6_first_start");
    step();
    chk("t6_count_queued", 64'(count), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async_reset");
    sb.delete();
    step();
    rst_n = 1'b1;
    base = n_starts;
    repeat (10) step();
    chk("t6_no_start_after_reset", 64'(n_starts), 64'(base));
    drive_push(mk(40), 1'b1);
    step();
    chk("t6_start_after_new_push", 64'(n_starts), 64'(base + 1));
`ifdef PRU_CMDQ_STATS_EN
    chk("t6_issued_cnt", 64'(issued_cnt), 64'd1);
`endif
    pulse_done();
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
